adsr_envelope: RTL and testbench
================================

# adsr_envelope

Downstream amplitude stage for the wave generators: accepts signed samples over a valid/ready handshake and scales each by an ADSR envelope level driven by a note gate. It emits the scaled samples to the mixer/DAC path. The envelope advances by one step per accepted sample, so envelope timing is expressed in samples at the sampling rate.

## Interface
- width_p, 12: sample width, signed two's complement, in and out
- env_width_p, 12: envelope level width, unsigned; full scale env_max = 2^env_width_p - 1
- clk_i  in  1: sole clock
- reset_n_i  in  1: asynchronous, active-low reset
- gate_i  in  1: note held (1) / released (0); synchronous to clk_i
- attack_step_i  in  env_width_p: level increment per sample in ATTACK
- decay_step_i  in  env_width_p: level decrement per sample in DECAY
- sustain_level_i  in  env_width_p: SUSTAIN hold level
- release_step_i  in  env_width_p: level decrement per sample in RELEASE
- valid_i  in  1: input sample valid
- data_i  in  width_p: input sample
- ready_o  out  1: block can accept data_i
- valid_o  out  1: data_o valid
- data_o  out  width_p: scaled sample
- ready_i  in  1: downstream accepts data_o
- level_o  out  env_width_p: current envelope level
- state_o  out  3: current adsr_state_e

## Operation
- Accept = valid_i & ready_o. Emit = valid_o & ready_i.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Level register L.
- Gate edges are detected against a registered copy of gate_i. Transitions are evaluated every clock, independent of sample traffic:
  - rising edge in any state -> ATTACK; L is kept, so a retrigger from RELEASE/DECAY ramps from the current level.
  - gate low in ATTACK, DECAY, or SUSTAIN -> RELEASE; L is kept.
- Level steps are applied on Accept cycles with no gate transition:
  - ATTACK: L = min(L + attack_step_i, env_max). On reaching env_max -> DECAY.
  - DECAY: L = max(L - decay_step_i, sustain_level_i). On reaching sustain_level_i -> SUSTAIN. If sustain_level_i >= L on entry, L = sustain_level_i and the state goes to SUSTAIN.
  - SUSTAIN: L = sustain_level_i, which tracks live changes.
  - RELEASE: L = max(L - release_step_i, 0). At 0 -> IDLE.
  - IDLE: L = 0.
- Gate transition and Accept in the same cycle: the transition wins and L is not stepped. The sample is still accepted and uses the pre-cycle L.
- A step of 0 holds L (no timeout).
- Arithmetic:
  - Step sums are computed at env_width_p+1 bits, then saturated.
  - Product = data_i * signed({1'b0, L}), width_p+env_width_p+1 bits.
  - data_o = product >>> env_width_p (arithmetic shift, floor, no rounding). This result always fits width_p.
- Each sample is scaled by L as registered at its Accept cycle, before that cycle's step.

## Timing
- Reset, asynchronous: state_o=IDLE, level_o=0, valid_o=0, data_o=0, and the gate register is 0. gate_i held high through reset release is therefore a rising edge on the first clock.
- One-entry output pipeline register. ready_o = ~valid_o | ready_i (combinational from ready_i).
- Latency: data_o/valid_o are valid the cycle after Accept.
- Accept and Emit in the same cycle give full throughput: one sample per clock.
- If valid_o=1 and ready_i=0, data_o/valid_o hold stable and ready_o=0.
- level_o and state_o are registered and update on the clock edge after the triggering event.
- Reset asserted mid-note aborts everything and drops any pending output.

## Structure
- adsr_pkg: adsr_state_e enum (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; 3 bits).
- Sub-module adsr_level_unit: FSM, gate edge detect, and saturating level arithmetic. Outputs level and state; input is the accept strobe.
- Top: handshake, multiplier, output register.

## Test plan
All scenarios use defaults width_p=12, env_width_p=12, env_max=4095.
- Reset: assert reset_n_i=0 mid-stream -> immediately valid_o=0, level_o=0, state_o=IDLE; after release, ready_o=1.
- Attack/decay: attack_step=1024, decay_step=512, sustain=2048, gate=1, continuous valid, ready_i=1.
  - Levels 0,1024,2048,3072,4095, then DECAY.
  - Then 3583,3071,2559,2048 and SUSTAIN.
- Scaling: at L=2048, data_i=1000 -> data_o=500; at L=4095, data_i=-2048 -> data_o=-2048; at L=0 -> data_o=0.
- Release/retrigger: gate low in SUSTAIN with release_step=1000 -> 1048, 48, 0 and IDLE. Gate high at L=1048 -> ATTACK ramps 1048 -> 2072.
- Backpressure: ready_i=0 for 5 cycles with valid_i=1 -> data_o stable, ready_o=0, L does not step; on ready_i=1, one sample per clock resumes with no loss or duplication.
- Simultaneous events: gate falls on an Accept cycle in ATTACK at L=1024 -> that sample is scaled by 1024, state goes to RELEASE, and L stays 1024 that cycle.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared types for the ADSR envelope amplitude stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package adsr_pkg;

  // Envelope phase; encoding is visible on state_o.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_e;

endpackage

// File: rtl/adsr_level_unit.sv
// Envelope FSM: gate edge detect plus saturating level stepping, one step per accepted sample.
// Latency: level_o/state_o update on the clock edge after a gate change or accept.
// Backpressure: none of its own; it steps only when the caller strobes accept_i.
module adsr_level_unit
  import adsr_pkg::*;
#(
  parameter int env_width_p = 12
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   gate_i,
  input  logic                   accept_i,
  input  logic [env_width_p-1:0] attack_step_i,
  input  logic [env_width_p-1:0] decay_step_i,
  input  logic [env_width_p-1:0] sustain_level_i,
  input  logic [env_width_p-1:0] release_step_i,
  output logic [env_width_p-1:0] level_o,
  output adsr_state_e            state_o
);

  localparam logic [env_width_p-1:0] env_max_lp = '1;

  logic                 gate_q;
  logic                 gate_rise;
  logic                 gate_drop;
  logic [env_width_p:0] attack_sum;
  logic [env_width_p:0] decay_diff;
  logic [env_width_p:0] release_diff;

  // A rising gate retriggers from any state; a low gate releases a held note.
  assign gate_rise = gate_i & ~gate_q;
  assign gate_drop = ~gate_i & ((state_o == ATTACK) | (state_o == DECAY) | (state_o == SUSTAIN));

  // One extra bit: carry out of the sum, or borrow (MSB set) out of a difference.
  assign attack_sum   = {1'b0, level_o} + {1'b0, attack_step_i};
  assign decay_diff   = {1'b0, level_o} - {1'b0, decay_step_i};
  assign release_diff = {1'b0, level_o} - {1'b0, release_step_i};

  // Gate transitions take priority over level stepping; the level is held across them.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gate_q  <= 1'b0;
      level_o <= '0;
      state_o <= IDLE;
    end else begin
      gate_q <= gate_i;
      if (gate_rise) begin
        state_o <= ATTACK;
      end else if (gate_drop) begin
        state_o <= RELEASE;
      end else if (accept_i) begin
        case (state_o)
          ATTACK: begin
            if (attack_sum >= {1'b0, env_max_lp}) begin
              level_o <= env_max_lp;
              state_o <= DECAY;
            end else begin
              level_o <= attack_sum[env_width_p-1:0];
            end
          end
          DECAY: begin
            // Covers a sustain target at or above the current level, a borrow,
            // and undershooting the target: all land exactly on sustain.
            if ((sustain_level_i >= level_o) || decay_diff[env_width_p] ||
                (decay_diff[env_width_p-1:0] <= sustain_level_i)) begin
              level_o <= sustain_level_i;
              state_o <= SUSTAIN;
            end else begin
              level_o <= decay_diff[env_width_p-1:0];
            end
          end
          SUSTAIN: begin
            level_o <= sustain_level_i;
          end
          RELEASE: begin
            if (release_diff[env_width_p] || (release_diff[env_width_p-1:0] == '0)) begin
              level_o <= '0;
              state_o <= IDLE;
            end else begin
              level_o <= release_diff[env_width_p-1:0];
            end
          end
          default: begin
            level_o <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Scales each accepted signed sample by the current ADSR envelope level (floor of data*L/2^env_width_p).
// Latency: one cycle from accept to valid_o; full throughput when accept and emit coincide.
// Backpressure: one-entry output register; ready_o = ~valid_o | ready_i, output held while ready_i=0.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int width_p     = 12,
  parameter int env_width_p = 12
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      gate_i,
  input  logic [env_width_p-1:0]    attack_step_i,
  input  logic [env_width_p-1:0]    decay_step_i,
  input  logic [env_width_p-1:0]    sustain_level_i,
  input  logic [env_width_p-1:0]    release_step_i,
  input  logic                      valid_i,
  input  logic signed [width_p-1:0] data_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic signed [width_p-1:0] data_o,
  input  logic                      ready_i,
  output logic [env_width_p-1:0]    level_o,
  output logic [2:0]                state_o
);

  localparam int prod_w_lp = width_p + env_width_p + 1;

  logic                        accept;
  adsr_state_e                 state;
  logic signed [prod_w_lp-1:0] data_ext;
  logic signed [prod_w_lp-1:0] level_ext;
  logic signed [prod_w_lp-1:0] product;
  logic                        unused_product_bits;

  assign ready_o = ~valid_o | ready_i;
  assign accept  = valid_i & ready_o;
  assign state_o = state;

  // Level is unsigned, so it enters the multiply with a zero sign bit.
  assign data_ext  = {{(env_width_p+1){data_i[width_p-1]}}, data_i};
  assign level_ext = {{width_p{1'b0}}, 1'b0, level_o};
  assign product   = data_ext * level_ext;

  // Dropping the low env_width_p bits is the arithmetic shift (floor); the top bit is
  // pure sign extension because |data*L| < 2^(width_p+env_width_p-1).
  assign unused_product_bits = ^{product[prod_w_lp-1], product[env_width_p-1:0]};

  adsr_level_unit #(
    .env_width_p (env_width_p)
  ) u_level (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .gate_i          (gate_i),
    .accept_i        (accept),
    .attack_step_i   (attack_step_i),
    .decay_step_i    (decay_step_i),
    .sustain_level_i (sustain_level_i),
    .release_step_i  (release_step_i),
    .level_o         (level_o),
    .state_o         (state)
  );

  // Output pipeline register: load on accept, clear once the held sample is taken.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (accept) begin
      valid_o <= 1'b1;
      data_o  <= product[env_width_p +: width_p];
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
module tb_adsr_envelope;
  localparam int W = 12;
  localparam int E = 12;
  localparam int ENV_MAX = 4095;
  localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

  logic                clk_i = 1'b0;
  logic                reset_n_i;
  logic                gate_i;
  logic [E-1:0]        attack_step_i, decay_step_i, sustain_level_i, release_step_i;
  logic                valid_i;
  logic signed [W-1:0] data_i;
  logic                ready_o;
  logic                valid_o;
  logic signed [W-1:0] data_o;
  logic                ready_i;
  logic [E-1:0]        level_o;
  logic [2:0]          state_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: envelope phase, level, last gate, pending output samples.
  int m_state, m_level;
  bit m_gate;
  int exp_q[$];

  typedef struct {
    bit gate;
    int data;
    int exp_data;
    int exp_level;
    int exp_state;
  } vec_t;
  vec_t tbl[15];

  adsr_envelope #(.width_p(W), .env_width_p(E)) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .gate_i          (gate_i),
    .attack_step_i   (attack_step_i),
    .decay_step_i    (decay_step_i),
    .sustain_level_i (sustain_level_i),
    .release_step_i  (release_step_i),
    .valid_i         (valid_i),
    .data_i          (data_i),
    .ready_o         (ready_o),
    .valid_o         (valid_o),
    .data_o          (data_o),
    .ready_i         (ready_i),
    .level_o         (level_o),
    .state_o         (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // floor(d * l / 2^E) by plain integer division with a floor correction.
  function automatic int scale(input int d, input int l);
    int p, q;
    p = d * l;
    q = p / 4096;
    if (p < 0 && (p % 4096) != 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_level = 0;
    m_state = S_IDLE;
    m_gate  = 1'b0;
  endtask

  task automatic model_edge(input bit acc);
    int a, d, s, r;
    a = int'(attack_step_i);
    d = int'(decay_step_i);
    s = int'(sustain_level_i);
    r = int'(release_step_i);
    if (gate_i && !m_gate) begin
      m_state = S_ATT;
    end else if (!gate_i && (m_state == S_ATT || m_state == S_DEC || m_state == S_SUS)) begin
      m_state = S_REL;
    end else if (acc) begin
      case (m_state)
        S_ATT: begin
          m_level = m_level + a;
          if (m_level >= ENV_MAX) begin m_level = ENV_MAX; m_state = S_DEC; end
        end
        S_DEC: begin
          if (s >= m_level) begin
            m_level = s; m_state = S_SUS;
          end else begin
            m_level = m_level - d;
            if (m_level <= s) begin m_level = s; m_state = S_SUS; end
          end
        end
        S_SUS: m_level = s;
        S_REL: begin
          m_level = m_level - r;
          if (m_level <= 0) begin m_level = 0; m_state = S_IDLE; end
        end
        default: m_level = 0;
      endcase
    end
    m_gate = gate_i;
  endtask

  // One clock: check ready_o, advance the model, cross the edge, compare outputs.
  task automatic tick();
    bit acc, emit;
    #1;
    chk("ready_o", int'(ready_o), (exp_q.size() == 0 || ready_i) ? 1 : 0);
    emit = (exp_q.size() > 0) && ready_i;
    acc  = valid_i && ((exp_q.size() == 0) || ready_i);
    if (emit) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(scale(int'(data_i), m_level));
    model_edge(acc);
    @(posedge clk_i);
    #1;
    chk("valid_o", int'(valid_o), (exp_q.size() > 0) ? 1 : 0);
    if (exp_q.size() > 0) chk("data_o", int'(data_o), exp_q[0]);
    chk("level_o", int'(level_o), m_level);
    chk("state_o", int'(state_o), m_state);
  endtask

  function automatic logic [E-1:0] rand_step();
    if ($urandom_range(0, 7) == 0) return '0;
    return E'($urandom_range(1, 1500));
  endfunction

  initial begin
    int n;
    tbl[0]  = '{1'b1,  1000,     0,    0, S_ATT};
    tbl[1]  = '{1'b1, -2048,     0, 1024, S_ATT};
    tbl[2]  = '{1'b1,  1000,   250, 2048, S_ATT};
    tbl[3]  = '{1'b1,  1000,   500, 3072, S_ATT};
    tbl[4]  = '{1'b1,  1000,   750, 4095, S_DEC};
    tbl[5]  = '{1'b1, -2048, -2048, 3583, S_DEC};
    tbl[6]  = '{1'b1,  1000,   874, 3071, S_DEC};
    tbl[7]  = '{1'b1,  1000,   749, 2559, S_DEC};
    tbl[8]  = '{1'b1,  1000,   624, 2048, S_SUS};
    tbl[9]  = '{1'b1,  1000,   500, 2048, S_SUS};
    tbl[10] = '{1'b0,  1000,   500, 2048, S_REL};
    tbl[11] = '{1'b0,  1000,   500, 1048, S_REL};
    tbl[12] = '{1'b0, -1000,  -256,   48, S_REL};
    tbl[13] = '{1'b0,  1000,    11,    0, S_IDLE};
    tbl[14] = '{1'b0,  1000,     0,    0, S_IDLE};

    reset_n_i = 1'b0;
    gate_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
    attack_step_i = 12'd1024; decay_step_i = 12'd512;
    sustain_level_i = 12'd2048; release_step_i = 12'd1000;
    model_reset();
    #12;
    chk("rst_state", int'(state_o), S_IDLE);
    chk("rst_level", int'(level_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_data", int'(data_o), 0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    chk("rst_ready", int'(ready_o), 1);

    // Attack/decay/sustain/release profile with scaling checks.
    valid_i = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      gate_i = tbl[i].gate;
      data_i = W'(tbl[i].data);
      tick();
      chk($sformatf("tbl%0d_valid", i), int'(valid_o), 1);
      chk($sformatf("tbl%0d_data", i), int'(data_o), tbl[i].exp_data);
      chk($sformatf("tbl%0d_level", i), int'(level_o), tbl[i].exp_level);
      chk($sformatf("tbl%0d_state", i), int'(state_o), tbl[i].exp_state);
    end

    // Gate falls on an accept cycle in ATTACK at L=1024.
    gate_i = 1'b1; data_i = 12'sd1000;
    tick();
    tick();
    chk("sim_pre_level", int'(level_o), 1024);
    gate_i = 1'b0;
    tick();
    chk("sim_data", int'(data_o), 250);
    chk("sim_state", int'(state_o), S_REL);
    chk("sim_level", int'(level_o), 1024);
    n = 0;
    while (int'(state_o) != S_IDLE && n < 20) begin tick(); n++; end
    chk("sim_to_idle", int'(state_o), S_IDLE);

    // Release then retrigger from L=1048.
    gate_i = 1'b1;
    n = 0;
    while (int'(state_o) != S_SUS && n < 20) begin tick(); n++; end
    chk("rt_sustain", int'(state_o), S_SUS);
    gate_i = 1'b0;
    tick();
    chk("rt_rel_level", int'(level_o), 2048);
    tick();
    chk("rt_1048", int'(level_o), 1048);
    gate_i = 1'b1;
    tick();
    chk("rt_att_state", int'(state_o), S_ATT);
    chk("rt_att_hold", int'(level_o), 1048);
    tick();
    chk("rt_2072", int'(level_o), 2072);
    chk("rt_data", int'(data_o), 255);

    // Backpressure for 5 cycles while in ATTACK, then resume.
    attack_step_i = 12'd100;
    data_i = 12'sd77;
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready", int'(ready_o), 0);
      chk("bp_valid", int'(valid_o), 1);
      chk("bp_data", int'(data_o), 255);
      chk("bp_level", int'(level_o), 2072);
    end
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_i = W'(100 * (i + 1));
      tick();
      if (i == 0) begin
        chk("resume_data0", int'(data_o), 50);
        chk("resume_level0", int'(level_o), 2172);
      end
    end

    // Asynchronous reset mid-stream.
    #3;
    reset_n_i = 1'b0;
    #1;
    chk("mrst_valid", int'(valid_o), 0);
    chk("mrst_level", int'(level_o), 0);
    chk("mrst_state", int'(state_o), S_IDLE);
    chk("mrst_data", int'(data_o), 0);
    model_reset();
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    #1;
    chk("mrst_ready", int'(ready_o), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) gate_i = ~gate_i;
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      data_i  = W'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        attack_step_i   = rand_step();
        decay_step_i    = rand_step();
        release_step_i  = rand_step();
        sustain_level_i = E'($urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
